// File: rtl/ittage_update_buffer_pkg.sv
// Shared frontend types for the ITTAGE commit-side update buffer:
// branch type encoding, ITTAGE prediction metadata and the update record.
package ittage_update_buffer_pkg;

  localparam int VADDR_W    = 39;
  localparam int OFFSET_W   = 20;
  localparam int REGION_W   = VADDR_W - OFFSET_W - 1;
  localparam int GHIST_W    = 16;
  localparam int PROVIDER_W = 4;
  localparam int CTR_W      = 2;

  typedef enum logic [2:0] {
    NOT_CFI,
    COND,
    DIRECT,
    CALL,
    RET,
    INDIRECT,
    INDIRECT_CALL
  } branch_type_e;

  // Targets are stored split into a shared region and per-entry halfword offset.
  typedef struct packed {
    logic [PROVIDER_W-1:0] provider;
    logic [REGION_W-1:0]   region;
    logic [OFFSET_W-1:0]   offset;
    logic [OFFSET_W-1:0]   alt_offset;
    logic [CTR_W-1:0]      ctr;
  } ittage_meta_t;

  typedef struct packed {
    logic [VADDR_W-1:0] start_addr;
    logic [VADDR_W-1:0] target_pc;
    logic [GHIST_W-1:0] sc_ghist;
    logic               tail_taken;
    branch_type_e       br_type;
    ittage_meta_t       meta;
  } ittage_upd_entry_t;

  function automatic logic is_indirect(branch_type_e t);
    return (t == INDIRECT) || (t == INDIRECT_CALL);
  endfunction

endpackage

// File: rtl/ittage_upd_filter.sv
// Combinational relevance filter: keep a commit record only if ITTAGE would
// change state on it (taken indirect jump/call that is not a no-op rewrite).
module ittage_upd_filter
  import ittage_update_buffer_pkg::*;
(
  input  ittage_upd_entry_t entry_i,
  output logic              keep_o
);

  logic [VADDR_W-1:0] main_pc;
  logic [VADDR_W-1:0] alt_pc;
  logic               noop;

  assign main_pc = {entry_i.meta.region, entry_i.meta.offset, 1'b0};
  assign alt_pc  = {entry_i.meta.region, entry_i.meta.alt_offset, 1'b0};

  // Saturated provider already pointing at the right target would rewrite identical state.
  assign noop = (|entry_i.meta.provider)
              & (main_pc == entry_i.target_pc)
              & (alt_pc == entry_i.target_pc)
              & (&entry_i.meta.ctr);

  assign keep_o = entry_i.tail_taken & is_indirect(entry_i.br_type) & ~noop;

endmodule

// File: rtl/ittage_update_buffer.sv
// First-word-fall-through staging FIFO feeding the ITTAGE update port.
// Define ITTAGE_UPD_BYPASS_EN to forward a keep record straight to the output when empty.
module ittage_update_buffer
  import ittage_update_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int FCNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  ittage_upd_entry_t       in_entry_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output ittage_upd_entry_t       out_entry_o,
  output logic [$clog2(DEPTH):0]  occupancy_o,
  output logic [FCNT_W-1:0]       filtered_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  ittage_upd_entry_t mem_q [DEPTH];

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic keep;
  logic consumed;
  logic stored_valid;
  logic push;
  logic pop;

  ittage_upd_filter u_filter (
    .entry_i (in_entry_i),
    .keep_o  (keep)
  );

  assign in_ready_o   = (occ_q != FULL);
  assign consumed     = in_valid_i & in_ready_o;
  assign stored_valid = (occ_q != '0);
  assign pop          = stored_valid & out_ready_i;

`ifdef ITTAGE_UPD_BYPASS_EN
  logic bypass;

  // An empty buffer with a ready consumer hands the record straight through.
  assign bypass      = consumed & keep & ~stored_valid & out_ready_i;
  assign push        = consumed & keep & ~bypass;
  assign out_valid_o = stored_valid | bypass;
  assign out_entry_o = bypass ? in_entry_i : mem_q[rptr_q];
`else
  assign push        = consumed & keep;
  assign out_valid_o = stored_valid;
  assign out_entry_o = mem_q[rptr_q];
`endif

  // NOTE: always_comb assigns every output a default first so no latch can be inferred.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    fcnt_d = fcnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (consumed && !keep && !(&fcnt_q)) fcnt_d = fcnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      fcnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      fcnt_q <= fcnt_d;
    end
  end

  // NOTE: the entry array is deliberately not reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_entry_i;
  end

  assign occupancy_o    = occ_q;
  assign filtered_cnt_o = fcnt_q;

endmodule

// File: tb/tb_ittage_update_buffer.sv
// Directed scoreboard bench for ittage_update_buffer (honours ITTAGE_UPD_BYPASS_EN).
module tb_ittage_update_buffer;
  import ittage_update_buffer_pkg::*;

  localparam int DEPTH  = 8;
  localparam int FCNT_W = 16;
`ifdef ITTAGE_UPD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  ittage_upd_entry_t in_entry;
  logic              out_valid;
  logic              out_ready;
  ittage_upd_entry_t out_entry;
  logic [3:0]        occupancy;
  logic [FCNT_W-1:0] filtered_cnt;

  ittage_upd_entry_t sb[$];
  logic [FCNT_W-1:0] fexp;
  int total = 0;
  int bad   = 0;

  ittage_update_buffer #(.DEPTH(DEPTH), .FCNT_W(FCNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_entry_i     (in_entry),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_entry_o    (out_entry),
    .occupancy_o    (occupancy),
    .filtered_cnt_o (filtered_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_keep(ittage_upd_entry_t e);
    logic ind;
    logic noop;
    ind  = (e.br_type == INDIRECT) || (e.br_type == INDIRECT_CALL);
    noop = (e.meta.provider != '0)
        && (e.target_pc == {e.meta.region, e.meta.offset, 1'b0})
        && (e.target_pc == {e.meta.region, e.meta.alt_offset, 1'b0})
        && (e.meta.ctr == '1);
    return e.tail_taken && ind && !noop;
  endfunction

  // Taken indirect record whose main offset misses the target, so it is never a no-op.
  function automatic ittage_upd_entry_t make_rec(int n);
    ittage_upd_entry_t e;
    e.start_addr      = VADDR_W'(32'h8000_0000 + n * 64);
    e.target_pc       = {REGION_W'($urandom), OFFSET_W'($urandom), 1'b0};
    e.sc_ghist        = GHIST_W'($urandom);
    e.tail_taken      = 1'b1;
    e.br_type         = n[0] ? INDIRECT_CALL : INDIRECT;
    e.meta.provider   = PROVIDER_W'($urandom);
    e.meta.region     = e.target_pc[VADDR_W-1 -: REGION_W];
    e.meta.offset     = e.target_pc[OFFSET_W:1] ^ OFFSET_W'(1);
    e.meta.alt_offset = e.target_pc[OFFSET_W:1];
    e.meta.ctr        = CTR_W'(n);
    return e;
  endfunction

  // Called at posedge+1: records this cycle's handshakes in the model, then advances one clock.
  task automatic step();
    ittage_upd_entry_t exp_e;
    #2;
    if (in_valid && in_ready) begin
      if (model_keep(in_entry)) sb.push_back(in_entry);
      else if (fexp != '1) fexp++;
    end
    if (out_valid && out_ready) begin
      check("pop_expected", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        exp_e = sb.pop_front();
        check("head_entry", 256'(out_entry), 256'(exp_e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && sb.size() != 0; k++) step();
    check({tag, "_sb_empty"}, 256'(sb.size()), 256'(0));
    check({tag, "_occ_zero"}, 256'(occupancy), 256'(0));
  endtask

  initial begin
    ittage_upd_entry_t e;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_entry  = '0;
    fexp      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_occ", 256'(occupancy), 256'(0));
    check("rst_fcnt", 256'(filtered_cnt), 256'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Three keep records with a ready consumer.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_entry  = make_rec(1);
    #1;
    check("t1_first_latency", 256'(out_valid), 256'(BYP));
    step();
    check("t1_valid_next", 256'(out_valid), 256'(1));
    in_entry = make_rec(2);
    step();
    in_entry = make_rec(3);
    step();
    in_valid = 1'b0;
    drain("t1");

    // Fill with a stalled consumer, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_entry = make_rec(10 + i);
      check("t2_ready_fill", 256'(in_ready), 256'(1));
      step();
    end
    in_entry = make_rec(18);
    check("t2_full_ready", 256'(in_ready), 256'(0));
    check("t2_full_occ", 256'(occupancy), 256'(DEPTH));
    check("t2_full_valid", 256'(out_valid), 256'(1));
    step();
    check("t2_ninth_held", 256'(occupancy), 256'(DEPTH));
    out_ready = 1'b1;
    #1;
    check("t2_full_pop_blocks", 256'(in_ready), 256'(0));
    step();
    check("t2_after_pop_ready", 256'(in_ready), 256'(1));
    check("t2_after_pop_occ", 256'(occupancy), 256'(DEPTH - 1));
    step();
    in_valid = 1'b0;
    check("t2_ninth_in", 256'(sb.size()), 256'(DEPTH - 1));
    drain("t2");

    // Records the filter must drop.
    e = make_rec(30);
    e.br_type    = INDIRECT_CALL;
    e.tail_taken = 1'b0;
    in_entry = e;
    in_valid = 1'b1;
    step();
    e = make_rec(31);
    e.br_type = COND;
    in_entry  = e;
    step();
    in_valid = 1'b0;
    check("t3_fcnt_model", 256'(filtered_cnt), 256'(fexp));
    check("t3_fcnt_two", 256'(filtered_cnt), 256'(2));
    check("t3_occ", 256'(occupancy), 256'(0));
    check("t3_out_valid", 256'(out_valid), 256'(0));

    // No-op record dropped; the same record one counter step below saturation is kept.
    e = make_rec(40);
    e.meta.provider   = 4'b0010;
    e.meta.ctr        = '1;
    e.meta.offset     = e.target_pc[OFFSET_W:1];
    e.meta.alt_offset = e.target_pc[OFFSET_W:1];
    in_entry = e;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t4_noop_fcnt", 256'(filtered_cnt), 256'(fexp));
    check("t4_noop_occ", 256'(occupancy), 256'(0));
    e.meta.ctr = 2'b10;
    in_entry   = e;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    check("t4_kept_occ", 256'(occupancy), 256'(1));
    check("t4_kept_head", 256'(out_entry), 256'(e));
    check("t4_fcnt_same", 256'(filtered_cnt), 256'(fexp));
    out_ready = 1'b1;
    drain("t4");

    // Sustained push+pop at DEPTH-1 across pointer wrap.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      in_entry = make_rec(100 + i);
      step();
    end
    check("t5_occ_fill", 256'(occupancy), 256'(DEPTH - 1));
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_entry = make_rec(200 + i);
      step();
      check("t5_occ_pushpop", 256'(occupancy), 256'(DEPTH - 1));
    end
    in_valid = 1'b0;
    drain("t5");

    // Asynchronous reset with five entries held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_entry = make_rec(300 + i);
      step();
    end
    in_valid = 1'b0;
    check("t6_occ_before", 256'(occupancy), 256'(5));
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_valid", 256'(out_valid), 256'(0));
    check("t6_async_occ", 256'(occupancy), 256'(0));
    check("t6_async_ready", 256'(in_ready), 256'(1));
    check("t6_async_fcnt", 256'(filtered_cnt), 256'(0));
    sb.delete();
    fexp = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    e        = make_rec(400);
    in_entry = e;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t6_post_valid", 256'(out_valid), 256'(1));
    check("t6_post_head", 256'(out_entry), 256'(e));
    check("t6_post_occ", 256'(occupancy), 256'(1));
    out_ready = 1'b1;
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
